cal_seq: RTL and testbench

Expression sequencer for the stack calculator. Accepts a stream of infix tokens (operands, operators, end marker) over a valid/ready handshake. Schedules operand and operator stack pushes and pops by operator precedence, and runs a fixed 3-cycle reduce sequence (pop operand, pop operand + operator, push result). Sits between the token source and the result consumer, and owns both stacks and the ALU step.

---
 rtl/cal_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_cal_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cal_seq.sv
// cal_seq: infix expression sequencer for the stack calculator.
// Owns the operand and operator stacks, schedules pushes and reductions
// by operator precedence and runs the 3-cycle reduce step
// (pop b, pop a + op, push a op b).
module cal_seq #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         tok_valid_i,
    output logic         tok_ready_o,
    input  logic [1:0]   tok_kind_i,
    input  logic [W-1:0] tok_data_i,
    output logic [W-1:0] result_o,
    output logic         done_o,
    output logic         busy_o,
    output logic         err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] KIND_OPND = 2'd0;
    localparam logic [1:0] KIND_OPER = 2'd1;
    localparam logic [1:0] KIND_END  = 2'd2;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_BAD = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        R_POPB,
        R_POPA,
        R_PUSH,
        DONE,
        ERR
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   opnd_q [DEPTH];
    logic [1:0]     oper_q [DEPTH];
    logic [CW-1:0]  opndCnt_q, opndCnt_d;
    logic [CW-1:0]  operCnt_q, operCnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   result_q, result_d;

    logic           opndWe, operWe;
    logic [W-1:0]   opndWdata;
    logic [1:0]     operWdata;
    logic [AW-1:0]  opndTopIdx, operTopIdx, opndPushIdx, operPushIdx;
    logic [W-1:0]   opndTop;
    logic [1:0]     operTop;
    logic [1:0]     newOp;
    logic           reduceFirst;
    logic [W-1:0]   aluRes;

    // Precedence rank: mul binds tighter than add/sub.
    function automatic logic [1:0] prec(input logic [1:0] op);
        return (op == OP_MUL) ? 2'd2 : 2'd1;
    endfunction

    assign opndTopIdx  = AW'(opndCnt_q - 1'b1);
    assign operTopIdx  = AW'(operCnt_q - 1'b1);
    assign opndPushIdx = AW'(opndCnt_q);
    assign operPushIdx = AW'(operCnt_q);
    assign opndTop     = opnd_q[opndTopIdx];
    assign operTop     = oper_q[operTopIdx];
    assign newOp       = tok_data_i[1:0];

    // Left-associative: an equal or higher precedence operator on top is reduced first.
    assign reduceFirst = (operCnt_q != '0) && (prec(operTop) >= prec(newOp));

    // ALU step on the operands staged by the reduce sequence; results wrap modulo 2^W.
    always_comb begin
        aluRes = '0;
        case (op_q)
            OP_ADD:  aluRes = a_q + b_q;
            OP_SUB:  aluRes = a_q - b_q;
            default: aluRes = a_q * b_q;
        endcase
    end

    // Next-state, stack control and token handshake; tok_ready never looks at tok_valid.
    always_comb begin
        state_d     = state_q;
        opndCnt_d   = opndCnt_q;
        operCnt_d   = operCnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        result_d    = result_q;
        opndWe      = 1'b0;
        operWe      = 1'b0;
        opndWdata   = tok_data_i;
        operWdata   = newOp;
        tok_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                case (tok_kind_i)
                    KIND_OPND: begin
                        tok_ready_o = 1'b1;
                        if (tok_valid_i) begin
                            if (opndCnt_q == FULL) begin
                                state_d = ERR;
                            end else begin
                                opndWe    = 1'b1;
                                opndCnt_d = opndCnt_q + 1'b1;
                            end
                        end
                    end
                    KIND_OPER: begin
                        if (newOp == OP_BAD) begin
                            tok_ready_o = 1'b1;
                            if (tok_valid_i) state_d = ERR;
                        end else if (reduceFirst) begin
                            if (tok_valid_i) state_d = R_POPB;
                        end else begin
                            tok_ready_o = 1'b1;
                            if (tok_valid_i) begin
                                if (operCnt_q == FULL) begin
                                    state_d = ERR;
                                end else begin
                                    operWe    = 1'b1;
                                    operCnt_d = operCnt_q + 1'b1;
                                end
                            end
                        end
                    end
                    KIND_END: begin
                        if (operCnt_q != '0) begin
                            if (tok_valid_i) state_d = R_POPB;
                        end else begin
                            tok_ready_o = 1'b1;
                            if (tok_valid_i) begin
                                if (opndCnt_q == CW'(1)) begin
                                    state_d  = DONE;
                                    result_d = opndTop;
                                end else begin
                                    state_d = ERR;
                                end
                            end
                        end
                    end
                    default: begin
                        tok_ready_o = 1'b1;
                        if (tok_valid_i) state_d = ERR;
                    end
                endcase
            end
            R_POPB: begin
                if (opndCnt_q < CW'(2)) begin
                    state_d = ERR;
                end else begin
                    b_d       = opndTop;
                    opndCnt_d = opndCnt_q - 1'b1;
                    state_d   = R_POPA;
                end
            end
            R_POPA: begin
                a_d       = opndTop;
                op_d      = operTop;
                opndCnt_d = opndCnt_q - 1'b1;
                operCnt_d = operCnt_q - 1'b1;
                state_d   = R_PUSH;
            end
            R_PUSH: begin
                opndWe    = 1'b1;
                opndWdata = aluRes;
                opndCnt_d = opndCnt_q + 1'b1;
                state_d   = IDLE;
            end
            DONE: begin
                opndCnt_d = '0;
                operCnt_d = '0;
                state_d   = IDLE;
            end
            ERR: begin
                tok_ready_o = 1'b1;
                if (tok_valid_i && (tok_kind_i == KIND_END)) begin
                    opndCnt_d = '0;
                    operCnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, stack pointers and staging registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            opndCnt_q <= '0;
            operCnt_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_ADD;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            opndCnt_q <= opndCnt_d;
            operCnt_q <= operCnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            result_q  <= result_d;
        end
    end

    // Stack storage; contents above the pointers are don't-care, so no reset.
    always_ff @(posedge clk_i) begin
        if (opndWe) opnd_q[opndPushIdx] <= opndWdata;
        if (operWe) oper_q[operPushIdx] <= operWdata;
    end

    assign result_o = result_q;
    assign done_o   = (state_q == DONE);
    assign busy_o   = (state_q != IDLE);
    assign err_o    = (state_q == ERR);

endmodule

// File: tb/tb_cal_seq.sv
// Testbench for cal_seq: directed token sequences, expected results pushed
// into a scoreboard queue and checked by a separate monitor on done.
module tb_cal_seq;

    localparam int W     = 8;
    localparam int DEPTH = 8;

    localparam logic [1:0] K_NUM = 2'd0;
    localparam logic [1:0] K_OP  = 2'd1;
    localparam logic [1:0] K_END = 2'd2;

    localparam logic [7:0] ADD = 8'd0;
    localparam logic [7:0] SUB = 8'd1;
    localparam logic [7:0] MUL = 8'd2;
    localparam logic [7:0] BAD = 8'd3;

    logic         clk = 1'b0;
    logic         rstN;
    logic         tokValid;
    logic         tokReady;
    logic [1:0]   tokKind;
    logic [W-1:0] tokData;
    logic [W-1:0] result;
    logic         done;
    logic         busy;
    logic         err;

    int           total = 0;
    int           bad = 0;
    int           doneCount = 0;
    logic [W-1:0] expQ [$];
    logic         errSeen = 1'b0;
    logic         donePrev = 1'b0;
    int           st;

    cal_seq #(.W(W), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .tok_valid_i(tokValid),
        .tok_ready_o(tokReady),
        .tok_kind_i (tokKind),
        .tok_data_i (tokData),
        .result_o   (result),
        .done_o     (done),
        .busy_o     (busy),
        .err_o      (err)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    // One comparison: counts it, reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
        end
    endtask

    // Present one token until accepted; reports cycles stalled by a reduce.
    task automatic applyStimulus(input logic [1:0] kind, input logic [7:0] data, output int stalls);
        logic rdy;
        logic accepted;
        stalls   = 0;
        accepted = 1'b0;
        @(negedge clk);
        tokValid = 1'b1;
        tokKind  = kind;
        tokData  = data;
        for (int n = 0; n < 64 && !accepted; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            rdy = tokReady;
            if (!rdy && busy) stalls++;
            @(posedge clk);
            if (rdy) accepted = 1'b1;
        end
        #1;
        tokValid = 1'b0;
        checkOutput("tokenAccepted", {31'd0, accepted}, 32'd1);
    endtask

    // Wait (bounded) for all queued results to be reported.
    task automatic waitDrain();
        for (int n = 0; n < 20 && expQ.size() != 0; n++) @(negedge clk);
        checkOutput("doneArrived", expQ.size(), 0);
    endtask

    // Monitor: every done pops one expected result.
    always @(negedge clk) begin
        if (rstN) begin
            if (err) errSeen = 1'b1;
            if (done && donePrev) checkOutput("donePulseWidth", 2, 1);
            if (done) begin
                doneCount++;
                if (expQ.size() == 0) checkOutput("unexpectedDone", 1, 0);
                else checkOutput("result", {24'd0, result}, {24'd0, expQ.pop_front()});
            end
            donePrev = done;
        end else begin
            donePrev = 1'b0;
        end
    end

    // Directed test sequence.
    initial begin
        rstN     = 1'b0;
        tokValid = 1'b0;
        tokKind  = K_NUM;
        tokData  = '0;
        repeat (2) @(negedge clk);
        checkOutput("resetReady", {31'd0, tokReady}, 1);
        checkOutput("resetBusy", {31'd0, busy}, 0);
        checkOutput("resetErr", {31'd0, err}, 0);
        checkOutput("resetDone", {31'd0, done}, 0);
        checkOutput("resetResult", {24'd0, result}, 0);
        rstN = 1'b1;

        // Precedence: 2 + 3 * 4 = 14, two reductions before end is taken.
        errSeen = 1'b0;
        applyStimulus(K_NUM, 8'd2, st);
        applyStimulus(K_OP, ADD, st);
        applyStimulus(K_NUM, 8'd3, st);
        applyStimulus(K_OP, MUL, st);
        checkOutput("mulNoStall", st, 0);
        applyStimulus(K_NUM, 8'd4, st);
        expQ.push_back(8'd14);
        applyStimulus(K_END, 8'd0, st);
        checkOutput("endStallCycles", st, 6);
        waitDrain();
        repeat (2) @(negedge clk);
        checkOutput("resultHeld", {24'd0, result}, 14);
        checkOutput("precErrFree", {31'd0, errSeen}, 0);

        // Left associativity and wraparound.
        applyStimulus(K_NUM, 8'd8, st);
        applyStimulus(K_OP, SUB, st);
        applyStimulus(K_NUM, 8'd3, st);
        applyStimulus(K_OP, SUB, st);
        checkOutput("subStall", st, 3);
        applyStimulus(K_NUM, 8'd2, st);
        expQ.push_back(8'd3);
        applyStimulus(K_END, 8'd0, st);
        waitDrain();
        applyStimulus(K_NUM, 8'd2, st);
        applyStimulus(K_OP, SUB, st);
        applyStimulus(K_NUM, 8'd3, st);
        expQ.push_back(8'd255);
        applyStimulus(K_END, 8'd0, st);
        waitDrain();
        applyStimulus(K_NUM, 8'd16, st);
        applyStimulus(K_OP, MUL, st);
        applyStimulus(K_NUM, 8'd16, st);
        expQ.push_back(8'd0);
        applyStimulus(K_END, 8'd0, st);
        waitDrain();

        // Operand stack overflow on the 9th operand.
        for (int i = 1; i <= 8; i++) applyStimulus(K_NUM, 8'(i), st);
        checkOutput("eightNoErr", {31'd0, err}, 0);
        applyStimulus(K_NUM, 8'd9, st);
        checkOutput("overflowErr", {31'd0, err}, 1);
        applyStimulus(K_NUM, 8'd5, st);
        applyStimulus(K_OP, ADD, st);
        checkOutput("errHolds", {31'd0, err}, 1);
        applyStimulus(K_END, 8'd0, st);
        checkOutput("errCleared", {31'd0, err}, 0);
        checkOutput("errIdle", {31'd0, busy}, 0);
        applyStimulus(K_NUM, 8'd3, st);
        applyStimulus(K_OP, MUL, st);
        applyStimulus(K_NUM, 8'd3, st);
        expQ.push_back(8'd9);
        applyStimulus(K_END, 8'd0, st);
        waitDrain();

        // Underflow: + then end fails at the first reduce.
        errSeen = 1'b0;
        applyStimulus(K_OP, ADD, st);
        applyStimulus(K_END, 8'd0, st);
        checkOutput("underflowStall", st, 1);
        checkOutput("underflowErrSeen", {31'd0, errSeen}, 1);
        checkOutput("underflowRecovered", {31'd0, err}, 0);

        // Illegal operator code.
        applyStimulus(K_OP, BAD, st);
        checkOutput("badOpErr", {31'd0, err}, 1);
        applyStimulus(K_END, 8'd0, st);
        checkOutput("badOpCleared", {31'd0, err}, 0);

        // Two operands left at end.
        applyStimulus(K_NUM, 8'd5, st);
        applyStimulus(K_NUM, 8'd6, st);
        applyStimulus(K_END, 8'd0, st);
        checkOutput("depth2Err", {31'd0, err}, 1);
        applyStimulus(K_END, 8'd0, st);
        checkOutput("depth2Cleared", {31'd0, err}, 0);

        // Backpressure: * held during a pending reduce, accepted once.
        applyStimulus(K_NUM, 8'd2, st);
        applyStimulus(K_OP, MUL, st);
        applyStimulus(K_NUM, 8'd3, st);
        applyStimulus(K_OP, MUL, st);
        checkOutput("backpressureStall", st, 3);
        applyStimulus(K_NUM, 8'd4, st);
        expQ.push_back(8'd24);
        applyStimulus(K_END, 8'd0, st);
        checkOutput("backpressureEnd", st, 3);
        waitDrain();

        // Reset while in R_POPA.
        applyStimulus(K_NUM, 8'd2, st);
        applyStimulus(K_OP, ADD, st);
        applyStimulus(K_NUM, 8'd3, st);
        @(negedge clk);
        tokValid = 1'b1;
        tokKind  = K_END;
        tokData  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("midReduceBusy", {31'd0, busy}, 1);
        rstN     = 1'b0;
        tokValid = 1'b0;
        #1;
        checkOutput("rstBusy", {31'd0, busy}, 0);
        checkOutput("rstErr", {31'd0, err}, 0);
        checkOutput("rstDone", {31'd0, done}, 0);
        checkOutput("rstResult", {24'd0, result}, 0);
        checkOutput("rstReady", {31'd0, tokReady}, 1);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(K_NUM, 8'd7, st);
        expQ.push_back(8'd7);
        applyStimulus(K_END, 8'd0, st);
        waitDrain();

        repeat (3) @(negedge clk);
        checkOutput("doneCount", doneCount, 7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
